led_sequencer: RTL and testbench

- Parametrised LED pattern generator: the next generation of the board-level LED "heartbeat" sequencer in the SoC.
- Runtime-selectable pattern mode, runtime step delay, enable and restart controls, configurable LED count and output polarity.
- Sits directly on the board LED pins.
- Driven by a CPU-visible control register or by tie-offs.

---
 rtl/led_sequencer_pkg.sv | 29 ++
 rtl/led_seq_prescaler.sv | 29 ++
 rtl/led_sequencer.sv | 118 +++++++++++
 tb/tb_led_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared encodings and helpers for the LED pattern sequencer.
package led_sequencer_pkg;

    // Pattern mode encodings as presented on the mode port.
    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    // Travel direction of the bounce pattern; left means towards the MSB.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Starting pattern for a mode, active-high, in the low 'width' bits.
    function automatic logic [31:0] init_pattern(input logic [1:0] mode, input int unsigned width);
        logic [31:0] ones;
        ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        case (mode)
            MODE_COUNT: return 32'd0;
            MODE_BLINK: return ones;
            default:    return 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-delay counter: asserts step once every delay+1 enabled cycles.
module led_seq_prescaler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] delay,
    output logic             step
);

    logic [CNT_W-1:0] r_cnt;

    // A >= compare means shrinking delay below the count steps at once.
    assign step = en && (r_cnt >= delay);

    // Counter restarts on clear or step, advances only while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || step) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern generator: bounce, rotate, binary count and blink patterns
// advanced by a programmable prescaler, with registered polarity-adjusted drive.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 32,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] delay,
    input  logic             restart,
    output logic [WIDTH-1:0] led,
    output logic             tick
);

    localparam logic [WIDTH-1:0] PAT_RESET = WIDTH'(1);
    localparam logic [WIDTH-1:0] LED_RESET = ACTIVE_LOW ? ~PAT_RESET : PAT_RESET;

    logic [WIDTH-1:0] r_pat;
    logic [WIDTH-1:0] r_pat_next;
    logic [WIDTH-1:0] r_led;
    dir_e             r_dir;
    dir_e             r_dir_next;
    mode_e            r_mode_q;
    mode_e            r_mode_q_next;
    logic             r_tick;
    logic             r_tick_next;

    logic             w_step;
    logic             w_mode_chg;
    logic             w_clear;
    logic [31:0]      w_init_full;
    logic [WIDTH-1:0] w_init;
    logic [WIDTH-1:0] w_led_next;

    assign w_mode_chg  = (mode != r_mode_q);
    assign w_clear     = restart || w_mode_chg;
    assign w_init_full = init_pattern(mode, WIDTH);
    assign w_init      = w_init_full[WIDTH-1:0];

    led_seq_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (w_clear),
        .delay (delay),
        .step  (w_step)
    );

    // Next pattern/direction/mode: restart beats mode change beats step.
    always_comb begin
        r_pat_next    = r_pat;
        r_dir_next    = r_dir;
        r_mode_q_next = r_mode_q;
        r_tick_next   = 1'b0;
        if (restart || w_mode_chg) begin
            r_pat_next    = w_init;
            r_dir_next    = DIR_LEFT;
            r_mode_q_next = mode_e'(mode);
        end else if (w_step) begin
            r_tick_next = 1'b1;
            case (r_mode_q)
                MODE_BOUNCE: begin
                    // Turn around on reaching an end so no end value repeats.
                    if (r_dir == DIR_LEFT && r_pat[WIDTH-1]) begin
                        r_dir_next = DIR_RIGHT;
                        r_pat_next = r_pat >> 1;
                    end else if (r_dir == DIR_RIGHT && r_pat[0]) begin
                        r_dir_next = DIR_LEFT;
                        r_pat_next = r_pat << 1;
                    end else if (r_dir == DIR_LEFT) begin
                        r_pat_next = r_pat << 1;
                    end else begin
                        r_pat_next = r_pat >> 1;
                    end
                end
                MODE_ROTATE: r_pat_next = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
                MODE_COUNT:  r_pat_next = r_pat + WIDTH'(1);
                MODE_BLINK:  r_pat_next = ~r_pat;
                default:     r_pat_next = r_pat;
            endcase
        end
    end

    // Per-bit output polarity applied to the next pattern so led and pat move together.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_polarity
            assign w_led_next[gi] = ACTIVE_LOW ? ~r_pat_next[gi] : r_pat_next[gi];
        end
    endgenerate

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat    <= PAT_RESET;
            r_dir    <= DIR_LEFT;
            r_mode_q <= MODE_BOUNCE;
            r_tick   <= 1'b0;
            r_led    <= LED_RESET;
        end else begin
            r_pat    <= r_pat_next;
            r_dir    <= r_dir_next;
            r_mode_q <= r_mode_q_next;
            r_tick   <= r_tick_next;
            r_led    <= w_led_next;
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised and directed check of two led_sequencer configurations
// (8 LEDs active-low, 4 LEDs active-high) against a step-count reference model.
module tb_led_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] delay;
    logic        restart;
    logic [7:0]  led8;
    logic [3:0]  led4;
    logic        tick8;
    logic        tick4;

    int n_chk;
    int n_err;

    // Reference model: mode, number of steps since the last init, prescaler count.
    int     m_mode;
    int     m_k;
    longint m_cnt;
    logic   m_tick;

    led_sequencer #(.WIDTH(8), .CNT_W(32), .ACTIVE_LOW(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .delay(delay),
        .restart(restart), .led(led8), .tick(tick8)
    );

    led_sequencer #(.WIDTH(4), .CNT_W(32), .ACTIVE_LOW(1'b0)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .delay(delay),
        .restart(restart), .led(led4), .tick(tick4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pattern after kk steps from the mode's starting value, for a w-LED strip.
    function automatic logic [31:0] exp_pat(input int m, input int kk, input int w);
        logic [31:0] mask;
        int per;
        int pos;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (m)
            0: begin
                per = 2 * (w - 1);
                pos = kk % per;
                if (pos > w - 1) pos = per - pos;
                return 32'd1 << pos;
            end
            1:       return 32'd1 << (kk % w);
            2:       return 32'(kk) & mask;
            default: return ((kk % 2) == 0) ? mask : 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_k    = 0;
        m_cnt  = 0;
        m_tick = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] p8;
        logic [31:0] p4;
        p8 = exp_pat(m_mode, m_k, 8);
        p4 = exp_pat(m_mode, m_k, 4);
        check_value({tag, " led8"}, {24'd0, led8}, {24'd0, ~p8[7:0]});
        check_value({tag, " led4"}, {28'd0, led4}, {28'd0, p4[3:0]});
        check_value({tag, " tick8"}, {31'd0, tick8}, {31'd0, m_tick});
        check_value({tag, " tick4"}, {31'd0, tick4}, {31'd0, m_tick});
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (restart || int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_k    = 0;
            m_cnt  = 0;
            m_tick = 1'b0;
        end else if (en && m_cnt >= longint'(delay)) begin
            m_k    = m_k + 1;
            m_cnt  = 0;
            m_tick = 1'b1;
        end else begin
            m_tick = 1'b0;
            if (en) m_cnt = m_cnt + 1;
        end
        #1;
        compare_all(tag);
        restart = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Drop reset between edges and confirm the outputs respond without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all({tag, " async"});
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        en      = 1'b1;
        mode    = 2'd0;
        delay   = 32'd3;
        restart = 1'b0;
        model_reset();

        #1 rst = 1'b0;
        #1;
        compare_all("reset");
        run("reset_hold", 2);
        #2 rst = 1'b1;
        $display("phase reset: checks=%0d errors=%0d", n_chk, n_err);

        run("delay3", 13);
        $display("phase delay3: checks=%0d errors=%0d", n_chk, n_err);

        delay = 32'd0;
        run("bounce", 20);
        $display("phase bounce: checks=%0d errors=%0d", n_chk, n_err);

        mode = 2'd1;
        run("rotate", 10);
        mode = 2'd2;
        run("count", 20);
        $display("phase rotate/count: checks=%0d errors=%0d", n_chk, n_err);

        delay = 32'd3;
        restart = 1'b1;
        run("count_d3", 22);
        mode = 2'd3;
        run("blink", 10);
        $display("phase mode_switch: checks=%0d errors=%0d", n_chk, n_err);

        delay = 32'd5;
        restart = 1'b1;
        run("pre_freeze", 2);
        en = 1'b0;
        run("frozen", 10);
        en = 1'b1;
        run("resume", 8);
        delay = 32'd0;
        restart = 1'b1;
        run("restart_step", 3);
        $display("phase freeze/restart: checks=%0d errors=%0d", n_chk, n_err);

        delay = 32'd100;
        restart = 1'b1;
        run("long_delay", 51);
        delay = 32'd2;
        run("short_delay", 5);
        async_reset("mid_period");
        run("after_rst", 6);
        $display("phase delay_shrink/async: checks=%0d errors=%0d", n_chk, n_err);

        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 8) != 0;
            if (($urandom % 40) == 0) mode = 2'($urandom % 4);
            if (($urandom % 30) == 0) delay = 32'($urandom % 7);
            if (($urandom % 50) == 0) restart = 1'b1;
            if (($urandom % 250) == 0) async_reset("rand");
            else cycle("rand");
        end
        $display("phase random: checks=%0d errors=%0d", n_chk, n_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
